serial_port_fifo_slave: RTL and testbench
=========================================

Name: serial_port_fifo_slave

Overview:
- Wishbone-style system-bus slave fronting a UART transmitter/receiver pair, with parametrised TX and RX FIFOs and a status/control register.
- Successor to the single-byte serial slave. The bus no longer blocks on UART timing: writes queue, reads pop, and full/empty conditions return retry.
- Everything, including the UART handshake, runs on one clock (clk_bus).

Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- RX_DEPTH, 16: RX FIFO entries; power of two, 2..256.
- DATA_W, 8: UART character width, 5..8; unused dat_o bits read 0.

Ports:
- clk_bus  in  1  single clock for bus and UART side.
- rst_bus  in  1  reset, synchronous, active-low.
- dat_i  in  32  bus write data.
- dat_o  out  32  bus read data.
- adr_i  in  32  bus address; only adr_i[2] decoded (0=DATA, 1=STATUS).
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- we_i  in  1  write enable.
- sel_i  in  4  byte selects; a write is effective only if sel_i[0]=1.
- ack_o  out  1  transfer done.
- rty_o  out  1  retry: FIFO full on write, or empty on read.
- err_o  out  1  tied 0.
- stall_o  out  1  request not accepted this cycle.
- uart_busy  in  1  transmitter busy.
- uart_ready  in  1  receiver holds a new character (level).
- uart_dat_i  in  8  received character.
- uart_start  out  1  one-cycle transmit pulse.
- uart_dat_o  out  8  character to transmit, stable from uart_start until uart_busy falls.

Behaviour:
- Reset (rst_bus=0 at a clk_bus edge):
  - Both FIFOs are emptied and the overrun flag is cleared.
  - The TX FSM goes to IDLE.
  - ack_o, rty_o, stall_o, uart_start and uart_dat_o become 0. dat_o becomes 0.
  - Reset mid-transfer abandons any pending ack; no response is issued.
- Bus acceptance:
  - A request is accepted at an edge where cyc_i & stb_i & !stall_o.
  - stall_o=1 exactly in the cycle after acceptance, which gives one outstanding transfer at a time.
  - The response (ack_o XOR rty_o) is a single-cycle pulse in the cycle after acceptance. Latency is 1.
- DATA write:
  - TX not full: push dat_i[DATA_W-1:0] and ack.
  - TX full: no push; rty_o.
- DATA read:
  - RX not empty: dat_o = head zero-extended, pop, ack.
  - RX empty: rty_o, dat_o=0.
- STATUS read (always acks). dat_o fields:
  - [0] rx_nonempty
  - [1] tx_not_full
  - [2] rx_overrun (sticky)
  - [3] tx_idle: TX FIFO empty and FSM in IDLE
  - [15:8] rx_count
  - [23:16] tx_count
  - others 0.
- STATUS write (acks):
  - dat_i[2]=1 clears rx_overrun.
  - dat_i[0]=1 flushes RX; dat_i[1]=1 flushes TX. A character already handed to the UART still completes.
- RX path:
  - Push uart_dat_i[DATA_W-1:0] on each rising edge of uart_ready (registered edge detect). uart_ready held high counts once.
  - RX full at the edge: the byte is dropped and rx_overrun is set.
  - Pop and edge in the same cycle with RX full: the pop takes effect first, the push succeeds, and there is no overrun.
  - Flush and edge in the same cycle: the flush wins and the byte is discarded.
- TX FSM:
  - IDLE: TX not empty and !uart_busy -> load uart_dat_o from head, pop, uart_start=1, go to START.
  - START: uart_start=0. uart_busy=1 -> BUSY. uart_busy still 0 -> WAIT (up to 15 cycles, then back to IDLE).
  - WAIT: uart_busy=1 -> BUSY.
  - BUSY: uart_busy=0 -> IDLE.
  - A bus push into an empty TX FIFO while IDLE yields uart_start no earlier than 1 cycle after the ack.
- Counts are log2(DEPTH)+1 bits wide and saturate neither way. Pointers wrap modulo DEPTH.
- Push to a full FIFO and pop from an empty FIFO are impossible by construction.

Test Plan:
- Reset, then read STATUS -> ack, dat_o=0x0000_000A (tx_not_full, tx_idle); stall_o, ack_o and uart_start are 0 throughout reset.
- Write 0x41, 0x42 to DATA with uart_busy modelled 10 cycles after each start -> 2 acks; uart_start pulses with uart_dat_o=0x41 then 0x42, in order, each pulse only after uart_busy fell; STATUS bit3 returns to 1.
- Hold uart_busy=1 and write TX_DEPTH+1 bytes -> the first 16 are acked, the 17th gets rty_o; STATUS[23:16]=16 and bit1=0.
- Deliver 3 uart_ready edges with bytes 0x10, 0x20, 0x30, then three DATA reads -> 0x10, 0x20, 0x30; a fourth read gives rty_o and dat_o=0.
- Fill RX with 16 bytes and deliver a 17th -> rx_overrun=1, RX contents unchanged. Repeat with a DATA read in the same cycle as the 17th edge -> no overrun, 17th byte stored. Write STATUS 0x4 -> overrun cleared.
- Assert rst_bus=0 for one cycle while a read ack is pending and the TX FSM is in BUSY -> no ack; FIFOs empty; next STATUS read = 0x0000_000A.

Source files
------------

// File: rtl/serial_port_fifo_slave.sv
// Bus slave fronting a UART with TX/RX FIFOs and a status/control register.
// One outstanding request at a time; the response follows acceptance by one cycle.
module serial_port_fifo_slave #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int DATA_W   = 8
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [31:0] adr_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic        rty_o,
  output logic        err_o,
  output logic        stall_o,
  input  logic        uart_busy,
  input  logic        uart_ready,
  input  logic [7:0]  uart_dat_i,
  output logic        uart_start,
  output logic [7:0]  uart_dat_o
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_WAIT, S_BUSY
  } tx_state_e;

  tx_state_e st_q, st_d;
  logic [3:0] wcnt_q, wcnt_d;

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [TAW-1:0] tx_wr_q, tx_rd_q;
  logic [RAW-1:0] rx_wr_q, rx_rd_q;
  logic [TCW-1:0] tx_cnt_q;
  logic [RCW-1:0] rx_cnt_q;
  logic ovr_q, rdy_q, stall_q;
  logic ack_q, ack_d, rty_q, rty_d;
  logic [31:0] dat_q, dat_d;
  logic start_q;
  logic [7:0] udat_q;

  logic acc, is_stat, ctl_wr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_edge;
  logic rx_flush, tx_flush, ovr_set, ovr_clr, tx_idle;
  logic [31:0] status;
  logic unused_ok;

  assign acc      = cyc_i & stb_i & ~stall_q;
  assign is_stat  = adr_i[2];
  assign tx_full  = (tx_cnt_q == TCW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push  = acc & ~is_stat & we_i & sel_i[0] & ~tx_full;
  assign rx_pop   = acc & ~is_stat & ~we_i & ~rx_empty;
  assign ctl_wr   = acc & is_stat & we_i & sel_i[0];
  assign rx_flush = ctl_wr & dat_i[0];
  assign tx_flush = ctl_wr & dat_i[1];
  assign ovr_clr  = ctl_wr & dat_i[2];

  // A pop in the same cycle frees the slot for an incoming byte.
  assign rx_edge  = uart_ready & ~rdy_q;
  assign rx_push  = rx_edge & ~rx_flush & (~rx_full | rx_pop);
  assign ovr_set  = rx_edge & ~rx_flush & rx_full & ~rx_pop;

  assign tx_idle  = tx_empty & (st_q == S_IDLE);
  assign status   = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q), 4'd0,
                     tx_idle, ovr_q, ~tx_full, ~rx_empty};

  always_comb begin
    ack_d = 1'b0;
    rty_d = 1'b0;
    dat_d = '0;
    if (acc) begin
      unique case ({is_stat, we_i})
        2'b00: begin
          if (rx_empty) begin
            rty_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            dat_d = 32'(rx_mem_q[rx_rd_q]);
          end
        end
        2'b01: begin
          rty_d = sel_i[0] & tx_full;
          ack_d = ~(sel_i[0] & tx_full);
        end
        2'b10: begin
          ack_d = 1'b1;
          dat_d = status;
        end
        default: ack_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_bus) begin
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      rty_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      stall_q <= acc;
      ack_q   <= ack_d;
      rty_q   <= rty_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_bus || rx_flush) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RAW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RAW'(1);
      rx_cnt_q <= rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_bus) begin
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      rdy_q <= uart_ready;
      if (ovr_set)      ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_bus) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= uart_dat_i[DATA_W-1:0];
    if (tx_push) tx_mem_q[tx_wr_q] <= dat_i[DATA_W-1:0];
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_bus || tx_flush) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TAW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TAW'(1);
      tx_cnt_q <= tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  // A flush blocks a new hand-off but never aborts one in flight.
  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    tx_pop = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (!tx_empty && !uart_busy && !tx_flush) begin
          tx_pop = 1'b1;
          st_d   = S_START;
        end
      end
      S_START: begin
        wcnt_d = '0;
        st_d   = uart_busy ? S_BUSY : S_WAIT;
      end
      S_WAIT: begin
        if (uart_busy)            st_d = S_BUSY;
        else if (wcnt_q == 4'd14) st_d = S_IDLE;
        else                      wcnt_d = wcnt_q + 4'd1;
      end
      default: begin
        if (!uart_busy) st_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_bus) begin
      st_q    <= S_IDLE;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      udat_q  <= '0;
    end else begin
      st_q    <= st_d;
      wcnt_q  <= wcnt_d;
      start_q <= tx_pop;
      if (tx_pop) udat_q <= 8'(tx_mem_q[tx_rd_q]);
    end
  end

  assign dat_o      = dat_q;
  assign ack_o      = ack_q;
  assign rty_o      = rty_q;
  assign err_o      = 1'b0;
  assign stall_o    = stall_q;
  assign uart_start = start_q;
  assign uart_dat_o = udat_q;

  assign unused_ok = ^{adr_i[31:3], adr_i[1:0], dat_i[31:3],
                       sel_i[3:1], uart_dat_i};
endmodule

// File: tb/tb_serial_port_fifo_slave.sv
// Bench for serial_port_fifo_slave: directed vector table, corner sequences,
// and randomized bus/RX traffic against a queue-based reference model.
module tb_serial_port_fifo_slave;
  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic [31:0] dat_i, dat_o, adr_i;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic        ack_o, rty_o, err_o, stall_o;
  logic        uart_busy, uart_ready, uart_start;
  logic [7:0]  uart_dat_i, uart_dat_o;

  int n_vec = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  logic busy_force = 1'b0;
  logic busy_auto = 1'b0;
  logic [7:0] starts[$];

  typedef struct {
    logic        we;
    logic        a2;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic        ack;
    logic        rty;
    logic [31:0] rd;
    logic        crd;
  } vec_t;

  serial_port_fifo_slave dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus),
    .dat_i(dat_i), .dat_o(dat_o), .adr_i(adr_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .ack_o(ack_o), .rty_o(rty_o),
    .err_o(err_o), .stall_o(stall_o),
    .uart_busy(uart_busy), .uart_ready(uart_ready),
    .uart_dat_i(uart_dat_i), .uart_start(uart_start),
    .uart_dat_o(uart_dat_o)
  );

  always #5 clk_bus = ~clk_bus;

  assign uart_busy = busy_force | (busy_cnt != 0);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // UART transmitter model: busy for 10 cycles after each start.
  always @(negedge clk_bus) begin
    if (uart_start) begin
      starts.push_back(uart_dat_o);
      if (busy_auto && !busy_force)
        chk("start_while_busy", 32'(uart_busy), 32'd0);
      if (busy_auto) busy_cnt = 10;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
  end

  task automatic bus(input logic we, input logic a2,
                     input logic [31:0] wd, input logic [3:0] sel,
                     output logic ack, output logic rty,
                     output logic [31:0] rd);
    int t;
    t = 0;
    while (stall_o && t < 20) begin
      @(negedge clk_bus);
      t++;
    end
    if (stall_o) chk("stall_timeout", 32'(stall_o), 32'd0);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
    adr_i = {29'd0, a2, 2'b00}; dat_i = wd; sel_i = sel;
    @(negedge clk_bus);
    ack = ack_o; rty = rty_o; rd = dat_o;
    chk("stall_after_accept", 32'(stall_o), 32'd1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_bus);
    chk("resp_single_pulse", {30'd0, ack_o, rty_o}, 32'd0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_dat_i = b; uart_ready = 1'b1;
    @(negedge clk_bus);
    uart_ready = 1'b0;
    @(negedge clk_bus);
  endtask

  function automatic vec_t mkv(logic we, logic a2, logic [31:0] wd,
                               logic [3:0] sel, logic ack, logic rty,
                               logic [31:0] rd, logic crd);
    vec_t v;
    v.we = we; v.a2 = a2; v.wd = wd; v.sel = sel;
    v.ack = ack; v.rty = rty; v.rd = rd; v.crd = crd;
    return v;
  endfunction

  // Reference model state for the random phase.
  logic [7:0] rxq[$];
  int m_txn = 0;
  logic m_ovr = 1'b0;

  function automatic logic [31:0] mstat();
    logic [7:0] tc, rc;
    tc = 8'(m_txn);
    rc = 8'(rxq.size());
    return {8'h00, tc, rc, 4'h0, m_txn == 0, m_ovr,
            m_txn < 16, rxq.size() > 0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    logic a, ry, ea, er;
    logic [31:0] rd, erd, wd;
    logic [3:0] sel;
    logic [7:0] b;
    int r, t;

    rst_bus = 1'b0; dat_i = '0; adr_i = '0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0;
    uart_ready = 1'b0; uart_dat_i = '0;

    // Reset and idle status
    repeat (4) begin
      @(negedge clk_bus);
      chk("in_reset", {29'd0, stall_o, ack_o, uart_start}, 32'd0);
    end
    rst_bus = 1'b1;
    @(negedge clk_bus);
    chk("reset_udat", 32'(uart_dat_o), 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("reset_stat_ack", {30'd0, a, ry}, 32'd2);
    chk("reset_stat", rd, 32'h0000_000A);

    // Two characters out through the transmitter
    busy_auto = 1'b1;
    starts.delete();
    bus(1'b1, 1'b0, 32'h41, 4'hF, a, ry, rd);
    chk("tx41_ack", {30'd0, a, ry}, 32'd2);
    bus(1'b1, 1'b0, 32'h42, 4'hF, a, ry, rd);
    chk("tx42_ack", {30'd0, a, ry}, 32'd2);
    t = 0;
    while (starts.size() < 2 && t < 100) begin
      @(negedge clk_bus);
      t++;
    end
    chk("tx_start_count", starts.size(), 32'd2);
    if (starts.size() >= 2) begin
      chk("tx_first", 32'(starts[0]), 32'h41);
      chk("tx_second", 32'(starts[1]), 32'h42);
    end
    repeat (20) @(negedge clk_bus);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("tx_done_stat", rd, 32'h0000_000A);

    // Vector table: RX reads, ignored byte-lane write, status
    rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30);
    tbl[0] = mkv(0, 1, 0,     4'hF, 1, 0, 32'h0000_030B, 1);
    tbl[1] = mkv(0, 0, 0,     4'hF, 1, 0, 32'h10, 1);
    tbl[2] = mkv(0, 0, 0,     4'hF, 1, 0, 32'h20, 1);
    tbl[3] = mkv(0, 0, 0,     4'hF, 1, 0, 32'h30, 1);
    tbl[4] = mkv(0, 0, 0,     4'hF, 0, 1, 32'h0, 1);
    tbl[5] = mkv(1, 0, 32'h5A, 4'hE, 1, 0, 32'h0, 0);
    tbl[6] = mkv(0, 1, 0,     4'hF, 1, 0, 32'h0000_000A, 1);
    tbl[7] = mkv(1, 1, 0,     4'hF, 1, 0, 32'h0, 0);
    tbl[8] = mkv(0, 1, 0,     4'hF, 1, 0, 32'h0000_000A, 1);
    for (int i = 0; i < 9; i++) begin
      bus(tbl[i].we, tbl[i].a2, tbl[i].wd, tbl[i].sel, a, ry, rd);
      chk($sformatf("tbl%0d_resp", i), {30'd0, a, ry},
          {30'd0, tbl[i].ack, tbl[i].rty});
      if (tbl[i].crd) chk($sformatf("tbl%0d_dat", i), rd, tbl[i].rd);
    end

    // RX overrun: 17th byte dropped
    for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i));
    rx_byte(8'hEE);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("ovr_stat", rd, 32'h0000_100F);
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 1'b0, 0, 4'hF, a, ry, rd);
      chk($sformatf("ovr_rd%0d", i), rd, 32'h80 + i);
    end
    bus(1'b0, 1'b0, 0, 4'hF, a, ry, rd);
    chk("ovr_empty_resp", {30'd0, a, ry}, 32'd1);
    chk("ovr_empty_dat", rd, 32'd0);
    bus(1'b1, 1'b1, 32'h4, 4'hF, a, ry, rd);
    chk("ovr_clr_ack", {30'd0, a, ry}, 32'd2);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("ovr_clr_stat", rd, 32'h0000_000A);

    // Pop and 17th edge in the same cycle
    for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i));
    uart_dat_i = 8'h77; uart_ready = 1'b1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    adr_i = 32'h0; sel_i = 4'hF;
    @(negedge clk_bus);
    chk("same_cyc_resp", {30'd0, ack_o, rty_o}, 32'd2);
    chk("same_cyc_dat", dat_o, 32'h80);
    cyc_i = 1'b0; stb_i = 1'b0; uart_ready = 1'b0;
    @(negedge clk_bus);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("same_cyc_stat", rd, 32'h0000_100B);
    for (int i = 1; i < 17; i++) begin
      bus(1'b0, 1'b0, 0, 4'hF, a, ry, rd);
      chk($sformatf("same_cyc_rd%0d", i), rd,
          (i == 16) ? 32'h77 : 32'h80 + i);
    end

    // TX full with transmitter held busy, then flush
    busy_force = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus(1'b1, 1'b0, 32'hA0 + i, 4'hF, a, ry, rd);
      chk($sformatf("txfull_wr%0d", i), {30'd0, a, ry},
          (i < 16) ? 32'd2 : 32'd1);
    end
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("txfull_stat", rd, 32'h0010_0000);
    bus(1'b1, 1'b1, 32'h2, 4'hF, a, ry, rd);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("txflush_stat", rd, 32'h0000_000A);
    busy_force = 1'b0;
    repeat (3) @(negedge clk_bus);

    // Reset during a pending read while the transmitter is busy
    starts.delete();
    rx_byte(8'h55);
    bus(1'b1, 1'b0, 32'h99, 4'hF, a, ry, rd);
    t = 0;
    while (starts.size() < 1 && t < 20) begin
      @(negedge clk_bus);
      t++;
    end
    chk("rst_tx_started", starts.size(), 32'd1);
    repeat (2) @(negedge clk_bus);
    rst_bus = 1'b0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    adr_i = 32'h0; sel_i = 4'hF;
    @(negedge clk_bus);
    chk("rst_no_resp", {29'd0, ack_o, rty_o, stall_o}, 32'd0);
    chk("rst_outs", {23'd0, uart_start, uart_dat_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst_bus = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_bus);
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("rst_stat", rd, 32'h0000_000A);
    bus(1'b0, 1'b0, 0, 4'hF, a, ry, rd);
    chk("rst_rx_empty", {30'd0, a, ry}, 32'd1);

    // Randomized traffic against the queue model
    busy_force = 1'b1;
    rxq.delete(); m_txn = 0; m_ovr = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        b = 8'($urandom);
        rx_byte(b);
        if (rxq.size() == 16) m_ovr = 1'b1;
        else rxq.push_back(b);
      end else if (r <= 4) begin
        sel = 4'($urandom); wd = $urandom;
        bus(1'b1, 1'b0, wd, sel, a, ry, rd);
        ea = 1'b1; er = 1'b0;
        if (sel[0]) begin
          if (m_txn == 16) begin
            ea = 1'b0; er = 1'b1;
          end else begin
            m_txn++;
          end
        end
        chk("rnd_wr", {30'd0, a, ry}, {30'd0, ea, er});
      end else if (r <= 6) begin
        bus(1'b0, 1'b0, $urandom, 4'($urandom), a, ry, rd);
        if (rxq.size() == 0) begin
          ea = 1'b0; er = 1'b1; erd = 0;
        end else begin
          ea = 1'b1; er = 1'b0; erd = 32'(rxq.pop_front());
        end
        chk("rnd_rd_resp", {30'd0, a, ry}, {30'd0, ea, er});
        chk("rnd_rd_dat", rd, erd);
      end else if (r <= 8) begin
        erd = mstat();
        bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
        chk("rnd_stat_resp", {30'd0, a, ry}, 32'd2);
        chk("rnd_stat", rd, erd);
      end else begin
        wd = {$urandom_range(0, 255), 24'd0} | $urandom_range(0, 7);
        sel = 4'($urandom);
        bus(1'b1, 1'b1, wd, sel, a, ry, rd);
        if (sel[0]) begin
          if (wd[2]) m_ovr = 1'b0;
          if (wd[0]) rxq.delete();
          if (wd[1]) m_txn = 0;
        end
        chk("rnd_ctl_resp", {30'd0, a, ry}, 32'd2);
      end
    end
    bus(1'b0, 1'b1, 0, 4'hF, a, ry, rd);
    chk("rnd_final_stat", rd, mstat());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
